// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared encodings, bus widths and FSM states for the RV32 execute stage
package ex_stage_pkg;

    localparam int RegBus      = 32;
    localparam int RegAddrBus  = 5;
    localparam int AluOpBus    = 8;
    localparam int AluSelBus   = 3;
    localparam int InstAddrBus = 32;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'd0;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'd1;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'd2;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'd3;
    localparam logic [AluSelBus-1:0] EXE_RES_MUL   = 3'd4;
    localparam logic [AluSelBus-1:0] EXE_RES_JUMP  = 3'd5;
    localparam logic [AluSelBus-1:0] EXE_RES_DIV   = 3'd6;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP    = 8'h00;
    localparam logic [AluOpBus-1:0] EXE_AND_OP    = 8'h01;
    localparam logic [AluOpBus-1:0] EXE_OR_OP     = 8'h02;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP    = 8'h03;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP    = 8'h04;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP    = 8'h05;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP    = 8'h06;
    localparam logic [AluOpBus-1:0] EXE_ADD_OP    = 8'h07;
    localparam logic [AluOpBus-1:0] EXE_SUB_OP    = 8'h08;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP    = 8'h09;
    localparam logic [AluOpBus-1:0] EXE_SLTU_OP   = 8'h0A;
    localparam logic [AluOpBus-1:0] EXE_MUL_OP    = 8'h10;
    localparam logic [AluOpBus-1:0] EXE_MULH_OP   = 8'h11;
    localparam logic [AluOpBus-1:0] EXE_MULHSU_OP = 8'h12;
    localparam logic [AluOpBus-1:0] EXE_MULHU_OP  = 8'h13;
    localparam logic [AluOpBus-1:0] EXE_DIV_OP    = 8'h14;
    localparam logic [AluOpBus-1:0] EXE_DIVU_OP   = 8'h15;
    localparam logic [AluOpBus-1:0] EXE_REM_OP    = 8'h16;
    localparam logic [AluOpBus-1:0] EXE_REMU_OP   = 8'h17;
    localparam logic [AluOpBus-1:0] EXE_JAL_OP    = 8'h20;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic op_is_div(input logic [AluOpBus-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
               (op == EXE_REM_OP) || (op == EXE_REMU_OP);
    endfunction

    function automatic logic op_is_rem(input logic [AluOpBus-1:0] op);
        return (op == EXE_REM_OP) || (op == EXE_REMU_OP);
    endfunction

    function automatic logic op_rs1_signed(input logic [AluOpBus-1:0] op);
        return (op == EXE_MUL_OP) || (op == EXE_MULH_OP) || (op == EXE_MULHSU_OP) ||
               (op == EXE_DIV_OP) || (op == EXE_REM_OP);
    endfunction

    function automatic logic op_rs2_signed(input logic [AluOpBus-1:0] op);
        return (op == EXE_MUL_OP) || (op == EXE_MULH_OP) ||
               (op == EXE_DIV_OP) || (op == EXE_REM_OP);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier (restoring divider with EX_DIV_EN)
module mul_div_unit
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AluOpBus-1:0] op,
    input  logic [RegBus-1:0]   opv1,
    input  logic [RegBus-1:0]   opv2,
    input  logic                hold,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [RegBus-1:0]   result
);

    localparam int CntW = $clog2(MUL_CYCLES + 1);

    md_state_t           state;
    logic [CntW-1:0]     cnt;
    logic [63:0]         acc;
    logic [63:0]         mcand;
    logic [31:0]         mplier;
    logic [AluOpBus-1:0] op_q;
    logic                neg;

    logic [63:0] acc_nx;
    logic [63:0] mcand_nx;
    logic [31:0] mplier_nx;
    logic [63:0] fin;
    logic        sa;
    logic        sb;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign sa    = op_rs1_signed(op) && opv1[31];
    assign sb    = op_rs2_signed(op) && opv2[31];
    assign abs_a = sa ? (~opv1 + 32'd1) : opv1;
    assign abs_b = sb ? (~opv2 + 32'd1) : opv2;

`ifdef EX_DIV_EN
    logic [32:0] r_sh;
    logic [32:0] diff;
    logic        div_neg;
    logic [31:0] quo_rem;

    // A zero divisor must yield all-ones regardless of operand signs.
    assign div_neg = op_is_rem(op) ? sa : ((sa ^ sb) && (opv2 != '0));
    assign quo_rem = op_is_rem(op_q) ? acc[31:0] : mplier;
`endif

    always_comb begin
        acc_nx    = mplier[0] ? (acc + mcand) : acc;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
`ifdef EX_DIV_EN
        r_sh = {acc[31:0], mplier[31]};
        diff = r_sh - {1'b0, mcand[31:0]};
        if (op_is_div(op_q)) begin
            mcand_nx  = mcand;
            mplier_nx = {mplier[30:0], ~diff[32]};
            acc_nx    = {32'd0, diff[32] ? r_sh[31:0] : diff[31:0]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            op_q   <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state  <= MD_BUSY;
                        op_q   <= op;
                        cnt    <= CntW'(MUL_CYCLES);
                        acc    <= '0;
                        mplier <= abs_b;
                        mcand  <= {32'd0, abs_a};
                        neg    <= sa ^ sb;
`ifdef EX_DIV_EN
                        if (op_is_div(op)) begin
                            mplier <= abs_a;
                            mcand  <= {32'd0, abs_b};
                            neg    <= div_neg;
                        end
`endif
                    end
                end
                MD_BUSY: begin
                    if (abort) begin
                        state <= MD_IDLE;
                    end else begin
                        acc    <= acc_nx;
                        mcand  <= mcand_nx;
                        mplier <= mplier_nx;
                        cnt    <= cnt - CntW'(1);
                        if (cnt == CntW'(1)) state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!hold) state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    always_comb begin
        fin    = neg ? (~acc + 64'd1) : acc;
        result = '0;
        if (state == MD_DONE) begin
            result = (op_q == EXE_MUL_OP) ? fin[31:0] : fin[63:32];
`ifdef EX_DIV_EN
            if (op_is_div(op_q)) result = neg ? (~quo_rem + 32'd1) : quo_rem;
`endif
        end
    end

    assign busy = ((state == MD_IDLE) && start) || ((state == MD_BUSY) && !abort);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32 execute stage: combinational ALU plus multi-cycle MUL (DIV with EX_DIV_EN)
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic [AluOpBus-1:0]    aluop_i,
    input  logic [AluSelBus-1:0]   alusel_i,
    input  logic [RegBus-1:0]      opv1_i,
    input  logic [RegBus-1:0]      opv2_i,
    input  logic [RegAddrBus-1:0]  reg_waddr_i,
    input  logic                   we_i,
    input  logic [InstAddrBus-1:0] link_addr_i,
    output logic [RegAddrBus-1:0]  reg_waddr_o,
    output logic                   we_o,
    output logic [RegBus-1:0]      wdata_o,
    output logic                   stallreq_o
);

    logic              md_start;
    logic              md_busy;
    logic              md_done;
    logic [RegBus-1:0] md_result;
    logic [RegBus-1:0] logic_res;
    logic [RegBus-1:0] shift_res;
    logic [RegBus-1:0] arith_res;
    logic [RegBus-1:0] alu_res;
    logic              alu_we;
    logic              unused_stall;

    assign unused_stall = ^{stall[5:4], stall[2:0]};

`ifdef EX_DIV_EN
    assign md_start = (alusel_i == EXE_RES_MUL) || (alusel_i == EXE_RES_DIV);
`else
    assign md_start = (alusel_i == EXE_RES_MUL);
`endif

    // A non-multicycle op reaching EX while busy means the pipeline flushed it.
    mul_div_unit #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_div (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (aluop_i),
        .opv1   (opv1_i),
        .opv2   (opv2_i),
        .hold   (stall[3]),
        .abort  (!md_start),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_AND_OP: logic_res = opv1_i & opv2_i;
            EXE_OR_OP:  logic_res = opv1_i | opv2_i;
            EXE_XOR_OP: logic_res = opv1_i ^ opv2_i;
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = opv1_i << opv2_i[4:0];
            EXE_SRL_OP: shift_res = opv1_i >> opv2_i[4:0];
            EXE_SRA_OP: shift_res = RegBus'($signed(opv1_i) >>> opv2_i[4:0]);
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_i)
            EXE_ADD_OP:  arith_res = opv1_i + opv2_i;
            EXE_SUB_OP:  arith_res = opv1_i - opv2_i;
            EXE_SLT_OP:  arith_res = {31'd0, $signed(opv1_i) < $signed(opv2_i)};
            EXE_SLTU_OP: arith_res = {31'd0, opv1_i < opv2_i};
            default:     arith_res = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_we  = we_i;
        case (alusel_i)
            EXE_RES_LOGIC: alu_res = logic_res;
            EXE_RES_SHIFT: alu_res = shift_res;
            EXE_RES_ARITH: alu_res = arith_res;
            EXE_RES_JUMP:  alu_res = link_addr_i;
            EXE_RES_MUL:   alu_res = md_done ? md_result : '0;
`ifdef EX_DIV_EN
            EXE_RES_DIV:   alu_res = md_done ? md_result : '0;
`endif
            default: begin
                alu_res = '0;
                alu_we  = 1'b0;
            end
        endcase
    end

    assign reg_waddr_o = rst ? '0 : reg_waddr_i;
    assign we_o        = rst ? 1'b0 : alu_we;
    assign wdata_o     = rst ? '0 : alu_res;
    assign stallreq_o  = rst ? 1'b0 : md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage (DIV cases with EX_DIV_EN)
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] opv1_i;
    logic [31:0] opv2_i;
    logic [4:0]  reg_waddr_i;
    logic        we_i;
    logic [31:0] link_addr_i;
    logic [4:0]  reg_waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .opv1_i      (opv1_i),
        .opv2_i      (opv2_i),
        .reg_waddr_i (reg_waddr_i),
        .we_i        (we_i),
        .link_addr_i (link_addr_i),
        .reg_waddr_o (reg_waddr_o),
        .we_o        (we_o),
        .wdata_o     (wdata_o),
        .stallreq_o  (stallreq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input logic we);
        alusel_i    = sel;
        aluop_i     = op;
        opv1_i      = a;
        opv2_i      = b;
        reg_waddr_i = wa;
        we_i        = we;
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            cycle();
        end
    endtask

    task automatic alu(input string tag, input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(sel, op, a, b, 5'd3, 1'b1);
        #1;
        check(tag, wdata_o, exp);
        cycle();
    endtask

    task automatic run_md(input string tag, input logic [2:0] sel, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        drive(sel, op, a, b, 5'd9, 1'b1);
        #1;
        count_stall(n);
        check({tag, "_lat"}, 32'(n), 32'd33);
        check(tag, wdata_o, exp);
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
        cycle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst         = 1'b1;
        stall       = 6'd0;
        link_addr_i = 32'h1000_0040;
        drive(EXE_RES_MUL, EXE_MUL_OP, 32'd4, 32'd5, 5'd7, 1'b1);
        cycle();
        cycle();
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_waddr", 32'(reg_waddr_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        rst = 1'b0;
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
        cycle();

        drive(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
        #1;
        check("add_wdata", wdata_o, 32'h8000_0000);
        check("add_we", 32'(we_o), 32'd1);
        check("add_waddr", 32'(reg_waddr_o), 32'd5);
        check("add_stallreq", 32'(stallreq_o), 32'd0);
        cycle();

        alu("sra",  EXE_RES_SHIFT, EXE_SRA_OP,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        alu("sll",  EXE_RES_SHIFT, EXE_SLL_OP,  32'h0000_0001, 32'd31,        32'h8000_0000);
        alu("srl",  EXE_RES_SHIFT, EXE_SRL_OP,  32'h8000_0000, 32'd31,        32'h0000_0001);
        alu("sltu", EXE_RES_ARITH, EXE_SLTU_OP, 32'd1,         32'hFFFF_FFFF, 32'd1);
        alu("slt",  EXE_RES_ARITH, EXE_SLT_OP,  32'hFFFF_FFFF, 32'd1,         32'd1);
        alu("sub",  EXE_RES_ARITH, EXE_SUB_OP,  32'd0,         32'd1,         32'hFFFF_FFFF);
        alu("xor",  EXE_RES_LOGIC, EXE_XOR_OP,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu("and",  EXE_RES_LOGIC, EXE_AND_OP,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu("jal",  EXE_RES_JUMP,  EXE_JAL_OP,  32'd0,         32'd0,         32'h1000_0040);

        drive(EXE_RES_NOP, EXE_NOP_OP, 32'h1234_5678, 32'd1, 5'd6, 1'b1);
        #1;
        check("nop_wdata", wdata_o, 32'd0);
        check("nop_we", 32'(we_o), 32'd0);
        cycle();

        // MUL followed directly by MULHU with no bubble.
        drive(EXE_RES_MUL, EXE_MUL_OP, 32'hFFFF_FFFD, 32'd7, 5'd9, 1'b1);
        #1;
        count_stall(n);
        check("mul_neg_lat", 32'(n), 32'd33);
        check("mul_neg", wdata_o, 32'hFFFF_FFEB);
        drive(EXE_RES_MUL, EXE_MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
        #1;
        check("b2b_gap", 32'(stallreq_o), 32'd0);
        cycle();
        count_stall(n);
        check("mulhu_lat", 32'(n), 32'd33);
        check("mulhu", wdata_o, 32'hFFFF_FFFE);
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
        cycle();

        run_md("mulh",   EXE_RES_MUL, EXE_MULH_OP,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_md("mulhsu", EXE_RES_MUL, EXE_MULHSU_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("mul_zero", EXE_RES_MUL, EXE_MUL_OP,  32'd0,         32'h0001_2345, 32'd0);

        stall = 6'b001000;
        drive(EXE_RES_MUL, EXE_MUL_OP, 32'd5, 32'd6, 5'd9, 1'b1);
        #1;
        count_stall(n);
        check("hold_lat", 32'(n), 32'd33);
        check("hold_done", wdata_o, 32'd30);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_keep", wdata_o, 32'd30);
            check("hold_nostall", 32'(stallreq_o), 32'd0);
        end
        stall = 6'd0;
        #1;
        check("hold_release", wdata_o, 32'd30);
        cycle();
        drive(EXE_RES_MUL, EXE_MUL_OP, 32'd2, 32'd2, 5'd9, 1'b1);
        #1;
        check("idle_after_release", 32'(stallreq_o), 32'd1);
        check("idle_wdata", wdata_o, 32'd0);
        cycle();
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        check("abort_stallreq", 32'(stallreq_o), 32'd0);
        cycle();
        run_md("after_abort", EXE_RES_MUL, EXE_MUL_OP, 32'd2, 32'd3, 32'd6);

        drive(EXE_RES_MUL, EXE_MUL_OP, 32'd9, 32'd9, 5'd9, 1'b1);
        #1;
        for (int i = 0; i < 10; i++) cycle();
        rst = 1'b1;
        #1;
        check("busy_rst_stallreq", 32'(stallreq_o), 32'd0);
        check("busy_rst_we", 32'(we_o), 32'd0);
        check("busy_rst_wdata", wdata_o, 32'd0);
        cycle();
        rst = 1'b0;
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b1);
        #1;
        check("post_rst_stallreq", 32'(stallreq_o), 32'd0);
        check("post_rst_we", 32'(we_o), 32'd0);
        run_md("mul_after_rst", EXE_RES_MUL, EXE_MUL_OP, 32'd2, 32'd3, 32'd6);

`ifdef EX_DIV_EN
        run_md("div_by_zero", EXE_RES_DIV, EXE_DIV_OP,  32'd7,         32'd0,         32'hFFFF_FFFF);
        run_md("rem_by_zero", EXE_RES_DIV, EXE_REM_OP,  32'd7,         32'd0,         32'd7);
        run_md("div_ovf",     EXE_RES_DIV, EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("rem_ovf",     EXE_RES_DIV, EXE_REM_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_md("div_neg",     EXE_RES_DIV, EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_md("rem_neg",     EXE_RES_DIV, EXE_REM_OP,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_md("divu",        EXE_RES_DIV, EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF);
        run_md("remu",        EXE_RES_DIV, EXE_REMU_OP, 32'd100,       32'd7,         32'd2);
`else
        drive(EXE_RES_DIV, EXE_DIV_OP, 32'd7, 32'd2, 5'd4, 1'b1);
        #1;
        check("div_off_wdata", wdata_o, 32'd0);
        check("div_off_we", 32'(we_o), 32'd0);
        check("div_off_stallreq", 32'(stallreq_o), 32'd0);
        cycle();
        check("div_off_stallreq2", 32'(stallreq_o), 32'd0);
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
        cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
